// File: rtl/gemm_pkg.sv
// Shared definitions for the sequential GEMM block: FSM states, width formulas
// and the packed-matrix element offset helper.
package gemm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Accumulator holds a sum of n products of two w-bit values without overflow.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n);
    endfunction

    function automatic int unsigned comb_width(input int unsigned w, input int unsigned n,
                                               input int unsigned cw);
        return acc_width(w, n) + cw + 1;
    endfunction

    // Row-major packing with element [0][0] in the MSBs.
    function automatic int unsigned elem_lsb(input int unsigned n, input int unsigned w,
                                             input int unsigned r, input int unsigned c);
        return ((n * n - 1) - (r * n + c)) * w;
    endfunction

endpackage

// File: rtl/gemm_mac.sv
// Dual multiply-accumulate with alpha/beta combine; the result is the scaled sum
// including the products presented this cycle, truncated to W bits.
module gemm_mac
    import gemm_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          last_i,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    input  logic [W-1:0]  c_i,
    input  logic [W-1:0]  d_i,
    input  logic [CW-1:0] alpha_i,
    input  logic [CW-1:0] beta_i,
    output logic [W-1:0]  res_o
);

    localparam int unsigned AW = acc_width(W, N);
    localparam int unsigned MW = comb_width(W, N, CW);

    logic [AW-1:0] acc_ab_q, acc_cd_q;
    logic [AW-1:0] sum_ab, sum_cd;

    assign sum_ab = acc_ab_q + AW'(a_i) * AW'(b_i);
    assign sum_cd = acc_cd_q + AW'(c_i) * AW'(d_i);

    // The last term of a dot product restarts the accumulators for the next element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_ab_q <= '0;
            acc_cd_q <= '0;
        end else if (clr_i) begin
            acc_ab_q <= '0;
            acc_cd_q <= '0;
        end else if (en_i) begin
            acc_ab_q <= last_i ? '0 : sum_ab;
            acc_cd_q <= last_i ? '0 : sum_cd;
        end
    end

    assign res_o = W'(MW'(alpha_i) * MW'(sum_ab) + MW'(beta_i) * MW'(sum_cd));

endmodule

// File: rtl/gemm_seq.sv
// Sequential N x N GEMM: Cout = alpha*(A x B) + beta*(C x D), one dual MAC per
// clock, with start/busy/done handshake.
module gemm_seq
    import gemm_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CW-1:0]      alpha,
    input  logic [CW-1:0]      beta,
    input  logic [N*N*W-1:0]   A,
    input  logic [N*N*W-1:0]   B,
    input  logic [N*N*W-1:0]   C,
    input  logic [N*N*W-1:0]   D,
    output logic [N*N*W-1:0]   Cout,
    output logic               busy,
    output logic               done
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned MW = N * N * W;
    localparam logic [MW-1:0] EL_MASK = MW'({W{1'b1}});

    state_t state_q, state_d;

    logic [IW-1:0] i_q, j_q, k_q;
    logic [MW-1:0] a_q, b_q, c_q, d_q, res_q, cout_q;
    logic [CW-1:0] alpha_q, beta_q;
    logic          busy_q, busy_d, done_q, done_d;
    logic          accept, step;
    logic          i_last, j_last, k_last;
    logic [31:0]   off_ik, off_kj, off_ij;
    logic [W-1:0]  mac_res;

    assign i_last = (i_q == IW'(N - 1));
    assign j_last = (j_q == IW'(N - 1));
    assign k_last = (k_q == IW'(N - 1));

    assign off_ik = elem_lsb(N, W, 32'(i_q), 32'(k_q));
    assign off_kj = elem_lsb(N, W, 32'(k_q), 32'(j_q));
    assign off_ij = elem_lsb(N, W, 32'(i_q), 32'(j_q));

    // busy stays up through the cycle after DONE so the next start lands at N^3+2.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (k_last && j_last && i_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (state_q == DONE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (state_q == DONE) cout_q <= res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            res_q   <= '0;
        end else if (accept) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= A;
            b_q     <= B;
            c_q     <= C;
            d_q     <= D;
            alpha_q <= alpha;
            beta_q  <= beta;
        end else if (step) begin
            if (k_last) begin
                k_q   <= '0;
                res_q <= (res_q & ~(EL_MASK << off_ij)) | (MW'(mac_res) << off_ij);
                if (j_last) begin
                    j_q <= '0;
                    i_q <= i_last ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    gemm_mac #(
        .N  (N),
        .W  (W),
        .CW (CW)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (accept),
        .en_i    (step),
        .last_i  (k_last),
        .a_i     (W'(a_q >> off_ik)),
        .b_i     (W'(b_q >> off_kj)),
        .c_i     (W'(c_q >> off_ik)),
        .d_i     (W'(d_q >> off_kj)),
        .alpha_i (alpha_q),
        .beta_i  (beta_q),
        .res_o   (mac_res)
    );

    assign Cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/gemm_seq.md
# gemm_seq

Parametrised, sequential successor to the team's single-cycle 2×2 GEMM block. Computes Cout = alpha·(A×B) + beta·(C×D) for N×N matrices of unsigned W-bit elements using one dual multiply-accumulate per clock, with a start/busy/done handshake. alpha and beta are run-time inputs rather than constants. Sits between the matrix operand registers and the result sink in the accelerator datapath.

## Interface
- N, default 2: matrix dimension (N ≥ 2).
- W, default 8: element width, inputs and outputs.
- CW, default 8: width of the alpha/beta coefficients.
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: request; sampled only in IDLE.
- alpha  in  CW: unsigned scale for A×B.
- beta  in  CW: unsigned scale for C×D.
- A, B, C, D  in  N·N·W each: row-major packed. Element [0][0] is in the MSBs, [N-1][N-1] in the LSBs.
- Cout  out  N·N·W: result, same packing.
- busy  out  1: high in RUN and DONE.
- done  out  1: one-cycle pulse when Cout updates.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - On a start=1 edge, latch A, B, C, D, alpha and beta into internal registers.
  - Clear i, j, k, acc_ab and acc_cd, then go to RUN.
  - Later changes to the input operands have no effect until the next accepted start.
- **RUN**, one step per cycle over (i, j, k), row-major, with k innermost.
  - Each cycle: acc_ab += A[i][k]·B[k][j] and acc_cd += C[i][k]·D[k][j].
  - When k = N-1:
    - Write res[i][j] = (alpha·acc_ab_final + beta·acc_cd_final) mod 2^W. Final accumulator values include the current products.
    - Clear both accumulators and advance j, then i.
  - After writing element [N-1][N-1], go to DONE.
- **DONE**: Cout ← res, done = 1, then go to IDLE.
- start is ignored in RUN and DONE. It is not queued.
- Arithmetic:
  - All arithmetic is unsigned.
  - Accumulators are 2W + clog2(N) bits, so there is no internal overflow.
  - The combine stage is 2W + clog2(N) + CW + 1 bits wide. Only the final result is truncated to its low W bits.
- Cout holds its value between completions. It never shows partial results.

## Timing
- Reset (async assert, sync release): state = IDLE; Cout = 0, busy = 0, done = 0; indices and accumulators = 0.
- Latency is measured from the edge that samples start = 1 (edge 0):
  - busy = 1 from edge 0.
  - RUN spans N³ cycles.
  - Cout and done = 1 are valid after edge N³+1.
  - busy = 0 and done = 0 after edge N³+2.
- Throughput: the next start is accepted at the earliest at edge N³+2. Total period is N³+2 cycles.
- Reset asserted mid-RUN or mid-DONE:
  - Aborts immediately and returns all outputs to their reset values.
  - No done pulse. Earlier Cout contents are lost.
- start held high continuously: a new operation begins on every IDLE cycle, which gives back-to-back runs.
- alpha = 0 or beta = 0: the run length is unchanged.

## Structure
- Shared package gemm_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - element-index helper functions that map (i, j) to the packed bit offset;
  - the accumulator- and combine-width localparam formulas.
- Sub-module gemm_mac holds:
  - the two W×W multipliers;
  - the two accumulators, with clear and enable inputs;
  - the alpha/beta combine and truncate stage.
- The top level holds the FSM, the index counters, the operand latches, res and Cout.

## Test plan
- **Basic result** (N=2, W=8). Stimulus: A = 32'h01020304, B = 32'h05060708, C = D = 32'h01000001, alpha = 2, beta = 1, one-cycle start. Required: Cout = 32'h272C5665, with done pulsing exactly 9 cycles after the start edge.
- **Truncation**. Stimulus: A = B = 32'hFFFFFFFF, C = D = 0, alpha = 1, beta = 0. Required: every element is 130050 mod 256, so Cout = 32'h02020202.
- **Beta path only**. Stimulus: alpha = 0, beta = 3, C = 32'h01020304, D = 32'h01000001 (identity). Required: Cout = 32'h0306090C.
- **Operand isolation and start while busy**:
  - Change A/B and pulse start during RUN. Required: the result matches the latched operands, there is a single done pulse, and a second run does not start.
  - Check busy = 1 through DONE.
- **Reset mid-run**. Stimulus: assert rst_n = 0 at cycle 4 of RUN. Required: Cout, busy and done go to 0 immediately, with no done pulse. A fresh start afterwards gives the correct result.
- **Scaling** (N=4, W=16, CW=8). Stimulus: random operands, start held high. Required: results match a reference model, and done pulses are spaced 66 cycles apart.
